// File: rtl/match_log_pkg.sv
// Shared definitions for the match event logger.
// Holds the default widths/depth and the event record layout (timestamp + sequence index).
package match_log_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_TS_W  = 16;
  localparam int DEF_CNT_W = 8;

  // One logged event at the default widths: when it happened and which match it was.
  typedef struct packed {
    logic [DEF_TS_W-1:0]  ts;
    logic [DEF_CNT_W-1:0] idx;
  } ev_t;

endpackage

// File: rtl/match_event_logger_if.sv
// Event stream between the logger and its consumer (valid/ready, FWFT head).
// Signals:
//   ev_valid : head event present (logger -> consumer)
//   ev_ready : consumer accepts the head this cycle (consumer -> logger)
//   ev_ts    : timestamp of the head event
//   ev_idx   : sequence index of the head event
interface match_event_logger_if #(
  parameter int TS_W  = match_log_pkg::DEF_TS_W,
  parameter int CNT_W = match_log_pkg::DEF_CNT_W
);
  logic             ev_valid;
  logic             ev_ready;
  logic [TS_W-1:0]  ev_ts;
  logic [CNT_W-1:0] ev_idx;

  modport master (output ev_valid, output ev_ts, output ev_idx, input ev_ready);
  modport slave  (input ev_valid, input ev_ts, input ev_idx, output ev_ready);
endinterface

// File: rtl/match_log_fifo.sv
// Synchronous first-word-fall-through FIFO for logged events.
// Ports:
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   i_push   : write i_data (accepted when not full, or when full with a pop)
//   i_pop    : remove the head (ignored while empty)
//   o_data   : head entry, read combinationally from storage
//   o_full, o_empty, o_level : occupancy status
module match_log_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd_ptr];
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Storage write; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/match_event_logger.sv
// Timestamps pulses from an upstream sequence detector and queues them for a consumer.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (has priority over everything)
//   match_in   : one-cycle match pulse, may repeat back to back
//   clear_cnt  : clears total_cnt and overflow (a same-cycle match/drop still counts)
//   ev_if      : event stream (master side), FWFT head of the event FIFO
//   total_cnt  : saturating count of matches seen
//   overflow   : sticky, set when an event had to be dropped
//   fifo_level : number of queued events
module match_event_logger
  import match_log_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TS_W  = DEF_TS_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   match_in,
  input  logic                   clear_cnt,
  match_event_logger_if.master   ev_if,
  output logic [CNT_W-1:0]       total_cnt,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_level
);
  logic [TS_W-1:0]       r_ts_cnt;
  logic [CNT_W-1:0]      r_seq_num;
  logic [CNT_W-1:0]      r_total;
  logic                  r_overflow;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [TS_W+CNT_W-1:0] w_head;

  assign w_pop  = ev_if.ev_valid && ev_if.ev_ready;
  assign w_push = match_in && (!w_full || w_pop);
  assign w_drop = match_in && !w_push;

  match_log_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TS_W + CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({r_ts_cnt, r_seq_num}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign ev_if.ev_valid = !w_empty;
  assign ev_if.ev_ts    = w_head[TS_W+CNT_W-1:CNT_W];
  assign ev_if.ev_idx   = w_head[CNT_W-1:0];
  assign total_cnt      = r_total;
  assign overflow       = r_overflow;

  // Free-running timestamp and per-match sequence number (advances on drops too).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts_cnt  <= '0;
      r_seq_num <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 1'b1;
      if (match_in) r_seq_num <= r_seq_num + 1'b1;
    end
  end

  // Saturating match counter; a clear coinciding with a match restarts at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_total <= '0;
    end else if (clear_cnt) begin
      r_total <= match_in ? CNT_W'(1) : CNT_W'(0);
    end else if (match_in && (r_total != {CNT_W{1'b1}})) begin
      r_total <= r_total + 1'b1;
    end
  end

  // Sticky drop flag; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (clear_cnt) begin
      r_overflow <= w_drop;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_match_event_logger.sv
module tb_match_event_logger;
  import match_log_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       match_in = 1'b0;
  logic       clear_cnt = 1'b0;
  logic [7:0] total_cnt;
  logic       overflow;
  logic [2:0] fifo_level;
  int         errors = 0;
  int         checks = 0;

  match_event_logger_if ev_if ();

  match_event_logger dut (
    .clk        (clk),
    .rst        (rst),
    .match_in   (match_in),
    .clear_cnt  (clear_cnt),
    .ev_if      (ev_if),
    .total_cnt  (total_cnt),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    ev_if.ev_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(ev_if.ev_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_total", 32'(total_cnt), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Match in the 6th cycle after release
    repeat (5) tick();
    match_in = 1'b1; tick(); match_in = 1'b0;
    check("first_valid", 32'(ev_if.ev_valid), 32'd1);
    check("first_ts", 32'(ev_if.ev_ts), 32'd5);
    check("first_idx", 32'(ev_if.ev_idx), 32'd0);
    check("first_level", 32'(fifo_level), 32'd1);
    check("first_total", 32'(total_cnt), 32'd1);

    // Pop only, then ready on empty FIFO
    ev_if.ev_ready = 1'b1; tick();
    check("pop_valid", 32'(ev_if.ev_valid), 32'd0);
    check("pop_level", 32'(fifo_level), 32'd0);
    tick(); ev_if.ev_ready = 1'b0;
    check("empty_ready_level", 32'(fifo_level), 32'd0);
    check("empty_ready_valid", 32'(ev_if.ev_valid), 32'd0);
    clear_cnt = 1'b1; tick(); clear_cnt = 1'b0;
    check("clear_total", 32'(total_cnt), 32'd0);

    // Five matches into a stalled FIFO
    rst = 1'b1; tick(); rst = 1'b0;
    match_in = 1'b1; repeat (5) tick(); match_in = 1'b0;
    check("fill_level", 32'(fifo_level), 32'd4);
    check("fill_ovf", 32'(overflow), 32'd1);
    check("fill_total", 32'(total_cnt), 32'd5);
    check("fill_idx", 32'(ev_if.ev_idx), 32'd0);
    check("fill_ts", 32'(ev_if.ev_ts), 32'd0);

    // Full FIFO with simultaneous push and pop
    ev_if.ev_ready = 1'b1; match_in = 1'b1; tick();
    ev_if.ev_ready = 1'b0; match_in = 1'b0;
    check("pp_level", 32'(fifo_level), 32'd4);
    check("pp_ovf", 32'(overflow), 32'd1);
    check("pp_total", 32'(total_cnt), 32'd6);
    check("pp_idx", 32'(ev_if.ev_idx), 32'd1);
    tick();
    check("hold_idx", 32'(ev_if.ev_idx), 32'd1);
    check("hold_ts", 32'(ev_if.ev_ts), 32'd1);
    check("hold_level", 32'(fifo_level), 32'd4);

    // Drain: idx 4 was dropped, idx 5 is the accepted tail
    ev_if.ev_ready = 1'b1;
    tick(); check("drain_idx2", 32'(ev_if.ev_idx), 32'd2);
    tick(); check("drain_idx3", 32'(ev_if.ev_idx), 32'd3);
    tick(); check("drain_idx5", 32'(ev_if.ev_idx), 32'd5);
    check("drain_ts5", 32'(ev_if.ev_ts), 32'd5);
    tick(); check("drain_empty", 32'(ev_if.ev_valid), 32'd0);
    ev_if.ev_ready = 1'b0;

    // Clear while dropping keeps overflow set
    match_in = 1'b1; repeat (4) tick();
    check("refill_total", 32'(total_cnt), 32'd10);
    clear_cnt = 1'b1; tick(); clear_cnt = 1'b0;
    check("clrdrop_total", 32'(total_cnt), 32'd1);
    check("clrdrop_ovf", 32'(overflow), 32'd1);
    check("clrdrop_level", 32'(fifo_level), 32'd4);
    ev_if.ev_ready = 1'b1; repeat (2) tick();
    match_in = 1'b0; tick();
    check("pre_clr_total", 32'(total_cnt), 32'd3);
    check("pre_clr_ovf", 32'(overflow), 32'd1);
    check("pre_clr_level", 32'(fifo_level), 32'd3);

    // Clear with a match that is accepted
    ev_if.ev_ready = 1'b0; clear_cnt = 1'b1; match_in = 1'b1; tick();
    clear_cnt = 1'b0; match_in = 1'b0;
    check("clr_total", 32'(total_cnt), 32'd1);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_level", 32'(fifo_level), 32'd4);

    // Mid-operation reset with three queued events
    ev_if.ev_ready = 1'b1; tick(); ev_if.ev_ready = 1'b0;
    check("mid_level", 32'(fifo_level), 32'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_valid", 32'(ev_if.ev_valid), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_total", 32'(total_cnt), 32'd0);
    match_in = 1'b1; tick(); match_in = 1'b0;
    check("post_rst_ts", 32'(ev_if.ev_ts), 32'd0);
    check("post_rst_idx", 32'(ev_if.ev_idx), 32'd0);

    // 300 matches streaming through
    rst = 1'b1; tick(); rst = 1'b0;
    ev_if.ev_ready = 1'b1; match_in = 1'b1;
    repeat (300) tick();
    ev_if.ev_ready = 1'b0; match_in = 1'b0;
    check("long_total", 32'(total_cnt), 32'd255);
    check("long_idx", 32'(ev_if.ev_idx), 32'd43);
    check("long_ts", 32'(ev_if.ev_ts), 32'd299);
    check("long_ovf", 32'(overflow), 32'd0);
    check("long_level", 32'(fifo_level), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/match_event_logger.md
MATCH_EVENT_LOGGER -- requirements
Module: match_event_logger

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning event FIFO entries (power of two, at least 2).
REQ-002 The block SHALL have parameter TS_W, default 16, meaning timestamp width.
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning width of the sequence index and the total counter.
REQ-004 The block SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-006 The block SHALL have port match_in  input  1  one-cycle pulse from the upstream sequence detector; may be high on consecutive cycles.
REQ-007 The block SHALL have port clear_cnt  input  1  clears total_cnt and overflow.
REQ-008 The block SHALL have port ev_ready  input  1  consumer ready.
REQ-009 The block SHALL have port ev_valid  output  1  FIFO head valid.
REQ-010 The block SHALL have port ev_ts  output  TS_W  timestamp of the head event.
REQ-011 The block SHALL have port ev_idx  output  CNT_W  sequence index of the head event.
REQ-012 The block SHALL have port total_cnt  output  CNT_W  count of matches seen, saturating.
REQ-013 The block SHALL have port overflow  output  1  sticky flag for a dropped event.
REQ-014 The block SHALL have port fifo_level  output  $clog2(DEPTH)+1  number of stored events.

Function
REQ-015 ts_cnt SHALL be a free-running TS_W counter: 0 in the first cycle after reset, +1 per cycle, wrapping modulo 2^TS_W.
REQ-016 seq_num SHALL be a CNT_W counter that increments on every match_in and wraps modulo 2^CNT_W, including on dropped events.
REQ-017 On a cycle with match_in=1, the event {ts=ts_cnt, idx=seq_num} SHALL be formed from the pre-increment values.
REQ-018 The event SHALL be pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
REQ-019 A pop SHALL occur when ev_valid && ev_ready.
REQ-020 Otherwise the event SHALL be dropped and overflow SHALL be set to 1.
REQ-021 The FIFO SHALL be first-word-fall-through: ev_valid = !empty; ev_ts/ev_idx show the head combinationally from storage.
REQ-022 Latency: a match at cycle t into an empty FIFO SHALL give ev_valid=1 at t+1.
REQ-023 Simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-024 A pop with no push SHALL decrement fifo_level.
REQ-025 A push with no pop SHALL increment fifo_level.
REQ-026 ev_ts/ev_idx SHALL hold stable while ev_valid=1 and ev_ready=0.
REQ-027 total_cnt SHALL increment on each match_in and saturate at 2^CNT_W-1.
REQ-028 clear_cnt=1 SHALL set total_cnt to 0, or to 1 if match_in=1 in the same cycle.
REQ-029 clear_cnt=1 SHALL set overflow to 0, or to 1 if a drop occurs in the same cycle.
REQ-030 clear_cnt SHALL NOT affect FIFO contents, ts_cnt or seq_num.
REQ-031 ev_ready while empty SHALL have no effect.

Reset
REQ-032 rst=1 SHALL, at the next edge, set ts_cnt, seq_num, total_cnt, overflow and fifo_level to 0, empty the FIFO, and set ev_valid to 0.
REQ-033 rst SHALL take priority over match_in, clear_cnt and ev_ready.
REQ-034 Reset asserted mid-operation SHALL discard queued events.
REQ-035 match_in during rst SHALL be ignored.

Structure
REQ-036 The event struct type (ts, idx) and the default widths SHALL live in shared package match_log_pkg.
REQ-037 The FIFO SHALL be sub-module match_log_fifo (synchronous, FWFT, push/pop/full/empty/level), instantiated once.
REQ-038 Counters and the overflow logic SHALL reside in match_event_logger.

Verification (DEPTH=4, TS_W=16, CNT_W=8)
REQ-039 A bench SHALL cover: release rst, match_in=1 in the 6th cycle after release -> next cycle ev_valid=1, ev_ts=5, ev_idx=0, fifo_level=1.
REQ-040 A bench SHALL cover: ev_ready=0, five consecutive match_in pulses -> fifo_level=4, overflow=1, total_cnt=5, head ev_idx=0; the idx=4 event is never delivered.
REQ-041 A bench SHALL cover: FIFO full, ev_ready=1 and match_in=1 in the same cycle -> fifo_level stays 4, overflow unchanged, new tail accepted.
REQ-042 A bench SHALL cover: total_cnt=3, overflow=1, then clear_cnt=1 with match_in=1 -> total_cnt=1, overflow=0, fifo_level+1.
REQ-043 A bench SHALL cover: fifo_level=3, rst pulse for one cycle -> ev_valid=0, fifo_level=0, total_cnt=0; first ts after release is 0.
REQ-044 A bench SHALL cover: 300 matches with ev_ready=1 -> total_cnt=255; last ev_idx=43 (299 mod 256); overflow=0.
